// File: rtl/trigger_pkg.sv
// Shared types and constants for the multi-stage trigger sequencer.
package trigger_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    DELAY,
    FIRED
  } trig_state_t;

  localparam logic [2:0] CFG_MASK  = 3'd0;
  localparam logic [2:0] CFG_VALUE = 3'd1;
  localparam logic [2:0] CFG_RISE  = 3'd2;
  localparam logic [2:0] CFG_FALL  = 3'd3;
  localparam logic [2:0] CFG_DELAY = 3'd4;
  localparam logic [2:0] CFG_CTRL  = 3'd5;

  // Fields are held at config-bus width; bits above the active width always read as zero.
  typedef struct packed {
    logic [31:0] mask;
    logic [31:0] value;
    logic [31:0] rise;
    logic [31:0] fall;
    logic [31:0] delay;
    logic        is_final;
  } trig_stage_cfg_t;

  // Keep only the low 'width' bits of a config word.
  function automatic logic [31:0] lsb_field(input logic [31:0] word, input int unsigned width);
    logic [31:0] keep;
    keep = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < int'(width)) keep[i] = 1'b1;
    end
    return word & keep;
  endfunction

endpackage

// File: rtl/trigger_stage_match.sv
// Combinational compare of one trigger stage: value/mask plus rising and falling edge terms.
module trigger_stage_match
  import trigger_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH = 8
) (
  input  trig_stage_cfg_t          cfg,
  input  logic [SAMPLE_WIDTH-1:0]  data_in,
  input  logic [SAMPLE_WIDTH-1:0]  prev,
  output logic                     match
);

  logic [31:0] cur;
  logic [31:0] old;
  logic        value_ok;
  logic        rise_ok;
  logic        fall_ok;

  // Delay and final flag are consumed by the sequencer, not here.
  logic unused_cfg;
  assign unused_cfg = ^{cfg.delay, cfg.is_final};

  // Evaluate all three terms at config width; upper config bits are zero so they never veto.
  always_comb begin
    cur      = 32'(data_in);
    old      = 32'(prev);
    value_ok = ((cur ^ cfg.value) & cfg.mask) == '0;
    rise_ok  = (~old & cur & cfg.rise) == cfg.rise;
    fall_ok  = (old & ~cur & cfg.fall) == cfg.fall;
    match    = value_ok && rise_ok && fall_ok;
  end

endmodule

// File: rtl/trigger_sequencer.sv
// Multi-stage trigger: per-stage match with optional delay, walked in order until the final stage.
module trigger_sequencer
  import trigger_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH = 8,
  parameter int unsigned NUM_STAGES   = 4,
  parameter int unsigned DELAY_WIDTH  = 16,
  parameter int unsigned STG_W        = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cfg_wr,
  input  logic [STG_W-1:0]        cfg_stage,
  input  logic [2:0]              cfg_sel,
  input  logic [31:0]             cfg_data,
  input  logic                    arm,
  input  logic                    disarm,
  input  logic                    valid,
  input  logic [SAMPLE_WIDTH-1:0] data_in,
  output logic                    run,
  output logic                    trig_pulse,
  output logic                    armed,
  output logic [STG_W-1:0]        level
);

  trig_state_t             state_q, state_d;
  logic [STG_W-1:0]        level_q, level_d;
  logic                    run_q, run_d;
  logic                    pulse_q, pulse_d;
  logic [DELAY_WIDTH-1:0]  cnt_q, cnt_d;
  logic                    first_q, first_d;
  logic [SAMPLE_WIDTH-1:0] prev_q, prev_eff;
  trig_stage_cfg_t         cfg_q [NUM_STAGES];
  logic [NUM_STAGES-1:0]   stage_match;
  logic [STG_W-1:0]        final_idx;
  trig_stage_cfg_t         sel_cfg;
  logic                    cfg_open;
  logic                    advance;

  assign cfg_open = (state_q == IDLE) || (state_q == FIRED);

  // Config register file; writes only land while the sequencer is not walking stages.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_STAGES); i++) cfg_q[i] <= '0;
    end else if (cfg_wr && cfg_open && (32'(cfg_stage) < NUM_STAGES)) begin
      case (cfg_sel)
        CFG_MASK:  cfg_q[cfg_stage].mask     <= lsb_field(cfg_data, SAMPLE_WIDTH);
        CFG_VALUE: cfg_q[cfg_stage].value    <= lsb_field(cfg_data, SAMPLE_WIDTH);
        CFG_RISE:  cfg_q[cfg_stage].rise     <= lsb_field(cfg_data, SAMPLE_WIDTH);
        CFG_FALL:  cfg_q[cfg_stage].fall     <= lsb_field(cfg_data, SAMPLE_WIDTH);
        CFG_DELAY: cfg_q[cfg_stage].delay    <= lsb_field(cfg_data, DELAY_WIDTH);
        CFG_CTRL:  cfg_q[cfg_stage].is_final <= cfg_data[0];
        default: ;
      endcase
    end
  end

  // The first valid sample after arm acts as its own predecessor, so it cannot form an edge.
  assign prev_eff = first_q ? data_in : prev_q;

  for (genvar g = 0; g < int'(NUM_STAGES); g++) begin : g_stage
    trigger_stage_match #(
      .SAMPLE_WIDTH(SAMPLE_WIDTH)
    ) u_match (
      .cfg     (cfg_q[g]),
      .data_in (data_in),
      .prev    (prev_eff),
      .match   (stage_match[g])
    );
  end

  // Final stage is the lowest flagged one, else the last stage.
  always_comb begin
    final_idx = STG_W'(NUM_STAGES - 1);
    for (int i = int'(NUM_STAGES) - 1; i >= 0; i--) begin
      if (cfg_q[i].is_final) final_idx = STG_W'(i);
    end
  end

  assign sel_cfg = cfg_q[level_q];

  // Next-state logic: disarm beats arm, arm beats a match.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    run_d   = run_q;
    pulse_d = 1'b0;
    cnt_d   = cnt_q;
    first_d = first_q && !valid;
    advance = 1'b0;

    unique case (state_q)
      IDLE, FIRED: begin
        if (arm) begin
          state_d = ARMED;
          level_d = '0;
          run_d   = 1'b0;
          cnt_d   = '0;
          first_d = 1'b1;
        end
      end
      ARMED: begin
        if (arm) begin
          level_d = '0;
          cnt_d   = '0;
          first_d = 1'b1;
        end else if (valid && stage_match[level_q]) begin
          if (sel_cfg.delay == '0) begin
            advance = 1'b1;
          end else begin
            state_d = DELAY;
            cnt_d   = DELAY_WIDTH'(sel_cfg.delay - 32'd1);
          end
        end
      end
      DELAY: begin
        if (arm) begin
          state_d = ARMED;
          level_d = '0;
          cnt_d   = '0;
          first_d = 1'b1;
        end else if (valid) begin
          if (cnt_q == '0) advance = 1'b1;
          else             cnt_d   = cnt_q - DELAY_WIDTH'(1);
        end
      end
    endcase

    if (advance) begin
      if (level_q == final_idx) begin
        state_d = FIRED;
        run_d   = 1'b1;
        pulse_d = 1'b1;
      end else begin
        state_d = ARMED;
        level_d = level_q + STG_W'(1);
      end
    end

    if (disarm) begin
      state_d = IDLE;
      level_d = '0;
      run_d   = 1'b0;
      pulse_d = 1'b0;
    end
  end

  // Sequencer state, delay counter and edge history.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      level_q <= '0;
      run_q   <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
      first_q <= 1'b0;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      run_q   <= run_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      if (valid) prev_q <= data_in;
    end
  end

  assign run        = run_q;
  assign trig_pulse = pulse_q;
  assign armed      = (state_q == ARMED) || (state_q == DELAY);
  assign level      = level_q;

endmodule

// File: tb/tb_trigger_sequencer.sv
// Scenario bench for trigger_sequencer: expected outputs queued with each stimulus step.
module tb_trigger_sequencer;
  import trigger_pkg::*;

  logic        clock;
  logic        reset;
  logic        cfg_wr;
  logic [1:0]  cfg_stage;
  logic [2:0]  cfg_sel;
  logic [31:0] cfg_data;
  logic        arm;
  logic        disarm;
  logic        valid;
  logic [7:0]  data_in;
  logic        run;
  logic        trig_pulse;
  logic        armed;
  logic [1:0]  level;

  trigger_sequencer #(
    .SAMPLE_WIDTH(8),
    .NUM_STAGES  (4),
    .DELAY_WIDTH (16)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .cfg_wr     (cfg_wr),
    .cfg_stage  (cfg_stage),
    .cfg_sel    (cfg_sel),
    .cfg_data   (cfg_data),
    .arm        (arm),
    .disarm     (disarm),
    .valid      (valid),
    .data_in    (data_in),
    .run        (run),
    .trig_pulse (trig_pulse),
    .armed      (armed),
    .level      (level)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic       run;
    logic       pulse;
    logic       armed;
    logic [1:0] level;
  } obs_t;

  typedef struct packed {
    logic       arm;
    logic       disarm;
    logic       valid;
    logic [7:0] data;
    obs_t       exp;
  } step_t;

  step_t steps[$];
  obs_t  exp_q[$];
  int    total = 0;
  int    bad   = 0;

  task automatic add(input logic a, input logic d, input logic v, input logic [7:0] x,
                     input logic r, input logic p, input logic ar, input logic [1:0] lv);
    step_t s;
    s.arm = a; s.disarm = d; s.valid = v; s.data = x;
    s.exp = {r, p, ar, lv};
    steps.push_back(s);
  endtask

  // Drive one cycle of stimulus, queue its expectation, return what the DUT shows after the edge.
  task automatic play(input step_t s, output obs_t o);
    arm = s.arm; disarm = s.disarm; valid = s.valid; data_in = s.data;
    exp_q.push_back(s.exp);
    @(posedge clock);
    #1;
    o = {run, trig_pulse, armed, level};
    arm = 1'b0; disarm = 1'b0; valid = 1'b0;
  endtask

  task automatic cfg(input logic [1:0] st, input logic [2:0] sel, input logic [31:0] d);
    cfg_wr = 1'b1; cfg_stage = st; cfg_sel = sel; cfg_data = d;
    @(posedge clock);
    #1;
    cfg_wr = 1'b0;
  endtask

  task automatic do_reset();
    arm = 1'b0; disarm = 1'b0; valid = 1'b0; cfg_wr = 1'b0;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    obs_t o;
    reset = 1'b1;
    #2;
    o = {run, trig_pulse, armed, level};
    total++;
    if (o !== 5'b0) begin
      bad++;
      $display("FAIL reset_state: got %b want 00000 (run,pulse,armed,level)", o);
    end
    @(posedge clock);
    #1;
    o = {run, trig_pulse, armed, level};
    total++;
    if (o !== 5'b0) begin
      bad++;
      $display("FAIL reset_held: got %b want 00000 (run,pulse,armed,level)", o);
    end
    reset = 1'b0;
  endtask

  task automatic test_value_match();
    obs_t o, e;
    do_reset();
    cfg(2'd0, CFG_MASK, 32'hFF);
    cfg(2'd0, CFG_VALUE, 32'h5A);
    cfg(2'd0, CFG_CTRL, 32'h1);
    add(1, 0, 0, 8'h00, 0, 0, 1, 2'd0);
    add(0, 0, 1, 8'h00, 0, 0, 1, 2'd0);
    add(0, 0, 1, 8'h5A, 1, 1, 0, 2'd0);
    add(0, 0, 0, 8'h00, 1, 0, 0, 2'd0);
    add(0, 0, 1, 8'h5A, 1, 0, 0, 2'd0);
    add(0, 1, 0, 8'h00, 0, 0, 0, 2'd0);
    foreach (steps[i]) begin
      play(steps[i], o);
      e = exp_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL value_match step %0d: got %b want %b (run,pulse,armed,level)", i, o, e);
      end
    end
    steps.delete();
  endtask

  task automatic test_two_stage();
    obs_t o, e;
    do_reset();
    cfg(2'd0, CFG_MASK, 32'hFF);
    cfg(2'd0, CFG_VALUE, 32'h01);
    cfg(2'd1, CFG_RISE, 32'h80);
    cfg(2'd1, CFG_CTRL, 32'h1);
    add(1, 0, 0, 8'h00, 0, 0, 1, 2'd0);
    add(0, 0, 1, 8'h80, 0, 0, 1, 2'd0);
    add(0, 0, 1, 8'h00, 0, 0, 1, 2'd0);
    add(0, 0, 1, 8'h80, 0, 0, 1, 2'd0);
    add(0, 0, 1, 8'h01, 0, 0, 1, 2'd1);
    add(0, 0, 1, 8'h00, 0, 0, 1, 2'd1);
    add(0, 0, 1, 8'h80, 1, 1, 0, 2'd1);
    add(1, 0, 0, 8'h00, 0, 0, 1, 2'd0);
    foreach (steps[i]) begin
      play(steps[i], o);
      e = exp_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL two_stage step %0d: got %b want %b (run,pulse,armed,level)", i, o, e);
      end
    end
    steps.delete();
  endtask

  task automatic test_delay();
    obs_t o, e;
    do_reset();
    cfg(2'd0, CFG_MASK, 32'h0F);
    cfg(2'd0, CFG_VALUE, 32'h0F);
    cfg(2'd0, CFG_DELAY, 32'h3);
    cfg(2'd0, CFG_CTRL, 32'h1);
    add(1, 0, 0, 8'h00, 0, 0, 1, 2'd0);
    add(0, 0, 1, 8'h00, 0, 0, 1, 2'd0);
    add(0, 0, 1, 8'h3F, 0, 0, 1, 2'd0);
    add(0, 0, 0, 8'h00, 0, 0, 1, 2'd0);
    add(0, 0, 1, 8'h00, 0, 0, 1, 2'd0);
    add(0, 0, 0, 8'h00, 0, 0, 1, 2'd0);
    add(0, 0, 1, 8'h00, 0, 0, 1, 2'd0);
    add(0, 0, 0, 8'h00, 0, 0, 1, 2'd0);
    add(0, 0, 1, 8'h00, 1, 1, 0, 2'd0);
    add(0, 0, 1, 8'h00, 1, 0, 0, 2'd0);
    foreach (steps[i]) begin
      play(steps[i], o);
      e = exp_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL delay step %0d: got %b want %b (run,pulse,armed,level)", i, o, e);
      end
    end
    steps.delete();
  endtask

  task automatic test_first_sample();
    obs_t o, e;
    do_reset();
    cfg(2'd0, CFG_RISE, 32'h01);
    cfg(2'd0, CFG_CTRL, 32'h1);
    add(1, 0, 0, 8'h00, 0, 0, 1, 2'd0);
    add(0, 0, 1, 8'h01, 0, 0, 1, 2'd0);
    add(0, 0, 1, 8'h00, 0, 0, 1, 2'd0);
    add(0, 0, 1, 8'h01, 1, 1, 0, 2'd0);
    foreach (steps[i]) begin
      play(steps[i], o);
      e = exp_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL first_sample step %0d: got %b want %b (run,pulse,armed,level)", i, o, e);
      end
    end
    steps.delete();
  endtask

  task automatic test_precedence();
    obs_t o, e;
    do_reset();
    cfg(2'd0, CFG_MASK, 32'hFF);
    cfg(2'd0, CFG_VALUE, 32'h01);
    cfg(2'd1, CFG_MASK, 32'hFF);
    cfg(2'd1, CFG_VALUE, 32'h02);
    cfg(2'd1, CFG_CTRL, 32'h1);
    // arm+disarm together while armed
    add(1, 0, 0, 8'h00, 0, 0, 1, 2'd0);
    add(0, 0, 1, 8'h01, 0, 0, 1, 2'd1);
    add(1, 1, 1, 8'h02, 0, 0, 0, 2'd0);
    // arm coincident with a level-1 match restarts at level 0
    add(1, 0, 0, 8'h00, 0, 0, 1, 2'd0);
    add(0, 0, 1, 8'h01, 0, 0, 1, 2'd1);
    add(1, 0, 1, 8'h02, 0, 0, 1, 2'd0);
    add(0, 0, 1, 8'h02, 0, 0, 1, 2'd0);
    foreach (steps[i]) begin
      play(steps[i], o);
      e = exp_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL precedence step %0d: got %b want %b (run,pulse,armed,level)", i, o, e);
      end
    end
    steps.delete();
    // Write while armed must be dropped: stage0 still wants 0x01, not 0x03.
    cfg(2'd0, CFG_VALUE, 32'h03);
    add(0, 1, 0, 8'h00, 0, 0, 0, 2'd0);
    add(1, 0, 0, 8'h00, 0, 0, 1, 2'd0);
    add(0, 0, 1, 8'h03, 0, 0, 1, 2'd0);
    add(0, 0, 1, 8'h01, 0, 0, 1, 2'd1);
    add(0, 1, 0, 8'h00, 0, 0, 0, 2'd0);
    foreach (steps[i]) begin
      play(steps[i], o);
      e = exp_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL cfg_locked step %0d: got %b want %b (run,pulse,armed,level)", i, o, e);
      end
    end
    steps.delete();
  endtask

  task automatic test_default_final();
    obs_t o, e;
    do_reset();
    add(1, 0, 0, 8'h00, 0, 0, 1, 2'd0);
    add(0, 0, 1, 8'h11, 0, 0, 1, 2'd1);
    add(0, 0, 0, 8'h22, 0, 0, 1, 2'd1);
    add(0, 0, 1, 8'h33, 0, 0, 1, 2'd2);
    add(0, 0, 1, 8'h44, 0, 0, 1, 2'd3);
    add(0, 0, 1, 8'h55, 1, 1, 0, 2'd3);
    add(0, 0, 1, 8'h66, 1, 0, 0, 2'd3);
    foreach (steps[i]) begin
      play(steps[i], o);
      e = exp_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL default_final step %0d: got %b want %b (run,pulse,armed,level)", i, o, e);
      end
    end
    steps.delete();
  endtask

  task automatic test_reset_mid_delay();
    obs_t o, e;
    do_reset();
    cfg(2'd0, CFG_DELAY, 32'h5);
    cfg(2'd0, CFG_CTRL, 32'h1);
    add(1, 0, 0, 8'h00, 0, 0, 1, 2'd0);
    add(0, 0, 1, 8'h00, 0, 0, 1, 2'd0);
    add(0, 0, 1, 8'h00, 0, 0, 1, 2'd0);
    foreach (steps[i]) begin
      play(steps[i], o);
      e = exp_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL mid_delay step %0d: got %b want %b (run,pulse,armed,level)", i, o, e);
      end
    end
    steps.delete();
    reset = 1'b1;
    #2;
    o = {run, trig_pulse, armed, level};
    total++;
    if (o !== 5'b0) begin
      bad++;
      $display("FAIL async_reset: got %b want 00000 (run,pulse,armed,level)", o);
    end
    reset = 1'b0;
    // Cleared config: delay 0, default final stage 3, so one valid sample advances to level 1.
    add(1, 0, 0, 8'h00, 0, 0, 1, 2'd0);
    add(0, 0, 1, 8'h00, 0, 0, 1, 2'd1);
    foreach (steps[i]) begin
      play(steps[i], o);
      e = exp_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL cfg_cleared step %0d: got %b want %b (run,pulse,armed,level)", i, o, e);
      end
    end
    steps.delete();
  endtask

  initial begin
    reset = 1'b1;
    cfg_wr = 1'b0; cfg_stage = '0; cfg_sel = '0; cfg_data = '0;
    arm = 1'b0; disarm = 1'b0; valid = 1'b0; data_in = '0;
    test_reset();
    test_value_match();
    test_two_stage();
    test_delay();
    test_first_sample();
    test_precedence();
    test_default_final();
    test_reset_mid_delay();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trigger_sequencer.md
Name: trigger_sequencer

Overview:
Parametrised multi-stage trigger, successor to the single-level rising/falling trigger. It is placed between the sampler output and the capture controller. Each of NUM_STAGES stages matches on value/mask plus rising/falling edges, with an optional per-stage delay counted in valid samples. Stages are walked in order, and `run` asserts when the final stage fires.

Parameters:
- SAMPLE_WIDTH, 8, width of sampled data
- NUM_STAGES, 4, number of trigger stages (≥1)
- DELAY_WIDTH, 16, width of per-stage delay counter
- STG_W, $clog2(NUM_STAGES) (min 1), derived stage index width

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cfg_wr  in  1  config write strobe
- cfg_stage  in  STG_W  target stage
- cfg_sel  in  3  register select: 0 mask, 1 value, 2 rise mask, 3 fall mask, 4 delay, 5 ctrl (bit0 = final)
- cfg_data  in  32  write data, LSB-aligned, upper bits ignored
- arm  in  1  start or restart sequence at stage 0
- disarm  in  1  abort to idle
- valid  in  1  sample qualifier from sampler
- data_in  in  SAMPLE_WIDTH  sample
- run  out  1  sticky trigger-fired level
- trig_pulse  out  1  one-cycle pulse on fire
- armed  out  1  high in ARMED or DELAY
- level  out  STG_W  current stage index

Behaviour:
- **Reset:** state IDLE; all config registers 0; run=0, trig_pulse=0, armed=0, level=0; delay counter 0; prev sample 0.
- **States:** IDLE, ARMED, DELAY, FIRED.
- **Config writes:**
  - Accepted only in IDLE or FIRED; ignored in ARMED and DELAY.
  - cfg_stage ≥ NUM_STAGES is ignored.
  - Write takes effect the next cycle.
- **Stage match:** combinational, qualified by valid.
  - Value term: ((data_in ^ value) & mask) == 0.
  - Rise term: (~prev & data_in & rise) == rise.
  - Fall term: (prev & ~data_in & fall) == fall.
  - The stage matches when all three terms hold.
- **Prev sample:**
  - Updated on every valid sample.
  - On arm, prev is loaded with the first valid sample before any edge evaluation: the first valid sample after arm never satisfies a nonzero rise or fall term.
- **Final stage:** the lowest-index stage with ctrl.final=1. If none is flagged, stage NUM_STAGES-1 is final.
- **IDLE:**
  - arm → ARMED, level=0, run=0.
  - disarm has no effect.
- **ARMED:** on valid with stage[level] match:
  - delay==0 and level is final → FIRED; run=1; trig_pulse=1 for one cycle.
  - delay==0 and level not final → level+1, stay ARMED.
  - delay>0 → DELAY; counter loaded with delay-1.
  - A non-match keeps the current level (no fall-back).
- **DELAY:**
  - Each valid sample decrements the counter.
  - On a valid sample with counter==0, perform the advance/fire action above.
  - The sample that completes the delay is not re-matched against the next stage.
  - A stage with delay d therefore fires on the d-th valid sample after its match sample.
- **FIRED:**
  - run held at 1.
  - arm → ARMED, level=0, run=0.
  - disarm → IDLE, run=0.
- **disarm:** from any state → IDLE, level=0, run=0, trig_pulse=0.
- **Simultaneous events:** disarm beats arm; arm beats a match in the same cycle (restart wins).
- **Latency:** outputs are registered, one cycle after the qualifying clock edge.
- **Timing:** no combinational path from inputs to outputs.
- **Reset mid-operation:** immediate async return to reset values, including config registers.
- **Delay counter:** DELAY_WIDTH bits, no wrap. A delay of 2^DELAY_WIDTH-1 is supported.

Decomposition:
- Shared package `trigger_pkg`:
  - state enum `trig_state_t` {IDLE, ARMED, DELAY, FIRED};
  - cfg_sel constants CFG_MASK, CFG_VALUE, CFG_RISE, CFG_FALL, CFG_DELAY, CFG_CTRL;
  - stage config struct `trig_stage_cfg_t` (mask, value, rise, fall, delay, final).
- One sub-module, `trigger_stage_match`: combinational per-stage compare (cfg, data_in, prev → match), instantiated NUM_STAGES times via generate.
- The sequencer FSM, config register file and delay counter live in the top module.

Test Plan:
1. **Value match.** Stage0 mask=FF, value=0x5A, final=1. Arm, feed valid 0x00, 0x5A → trig_pulse one cycle after the 0x5A edge; run stays 1; level=0.
2. **Two-stage sequence.** Stage0 value=0x01 mask=FF; stage1 rise=0x80, final. Feed 0x01, 0x00, 0x80 → level 0→1 after 0x01; fire after 0x80; 0x80 before 0x01 does not fire.
3. **Delay.** Stage0 value=0x0F mask=0F, delay=3, final. Match at sample k → run asserts after valid sample k+3. Non-valid cycles interleaved do not advance the counter.
4. **First sample after arm.** Stage0 rise=0x01. Arm with data_in=0x01 on the first valid → no fire. Then 0x00, 0x01 → fire.
5. **Control precedence.**
   - arm and disarm in the same cycle while ARMED → IDLE, armed=0.
   - arm coincident with a matching sample at level 1 → level=0, no advance.
   - cfg_wr during ARMED → register unchanged (read back by behaviour after disarm).
6. **Default final and reset.**
   - No final flag set, NUM_STAGES=4, all masks 0 → fires after exactly 4 valid samples.
   - Assert reset mid-DELAY → run=0, armed=0, level=0 immediately, and the config is cleared.
